ff_response_checker: RTL and testbench
======================================

FF_RESPONSE_CHECKER -- requirements
Module: ff_response_checker

Interface
REQ-001 Parameter CNT_W, default 16, width of the compared-cycle counter.
REQ-002 Parameter ERR_W, default 8, width of the error counter.
REQ-003 Parameter STOP_ON_ERR, default 0; when 1, first error freezes checking.
REQ-004 clk  input  1  single clock; all state updates on posedge clk.
REQ-005 clear  input  1  reset, synchronous, active-high.
REQ-006 en  input  1  check enable; when 0, no state, counter or sample register changes.
REQ-007 d_in  input  1  D stimulus, driven to the flip-flop under test on the same clk.
REQ-008 q_in  input  1  Q output of the flip-flop under test.
REQ-009 qbar_in  input  1  Qbar output of the flip-flop under test.
REQ-010 mismatch  output  1  one-cycle pulse on a failed compare.
REQ-011 err_q  output  1  registered: the failing compare involved Q.
REQ-012 err_comp  output  1  registered: the failing compare involved Qbar != ~Q.
REQ-013 check_cnt  output  CNT_W  number of compares performed, saturating.
REQ-014 err_cnt  output  ERR_W  number of failed compares, saturating.
REQ-015 pass  output  1  high when in CHECK state and err_cnt == 0.
REQ-016 halted  output  1  high in HALT state.

Function
REQ-017 Required DUT behaviour: Q after edge k equals d_in sampled at edge k; Qbar == ~Q at all times.
REQ-018 States: IDLE, PRIME, CHECK, HALT.
REQ-019 IDLE: on en=1 capture d_in into d_prev, go to PRIME; no compare.
REQ-020 PRIME: on en=1 capture d_in into d_prev, go to CHECK; no compare (first DUT output undefined).
REQ-021 CHECK: on en=1 compare q_in to d_prev and qbar_in to ~q_in, then capture d_in into d_prev.
REQ-022 Each CHECK compare increments check_cnt by 1, saturating at all-ones.
REQ-023 On failed compare: mismatch=1 for the following cycle, err_q/err_comp set per failing term (both if both fail), err_cnt +1 saturating at all-ones.
REQ-024 err_q/err_comp hold their value until the next failed compare or clear.
REQ-025 Passed compare drives mismatch=0 next cycle; err_q/err_comp unchanged.
REQ-026 STOP_ON_ERR=1: failed compare moves CHECK to HALT; HALT is exited only by clear; counters frozen.
REQ-027 STOP_ON_ERR=0: state remains CHECK after failures.
REQ-028 en=0 in any state: state, d_prev and counters hold; mismatch driven 0; the next enabled compare uses the held d_prev.
REQ-029 Latency: mismatch and counter updates visible one clk after the edge where the failing q_in is sampled.
REQ-030 X/Z on q_in or qbar_in during a compare counts as a failure (equality compare must treat unknown as mismatch).

Reset
REQ-031 clear=1 at posedge clk: state=IDLE, d_prev=0, check_cnt=0, err_cnt=0, mismatch=0, err_q=0, err_comp=0, pass=0, halted=0.
REQ-032 clear takes priority over en and over any compare in the same cycle; a mid-run clear discards that cycle's compare.
REQ-033 Outputs are undefined before the first clear edge; bench shall apply clear for at least 1 cycle at start.

Structure
REQ-034 Shared package ff_check_pkg holds the state enumeration and default CNT_W/ERR_W constants.
REQ-035 One sub-module sat_counter (parameterised width, inc, clear, saturating) instantiated for check_cnt and err_cnt.
REQ-036 State register, d_prev and flags in ff_response_checker; no combinational path from inputs to outputs except none (all outputs registered; pass/halted decoded from registered state and err_cnt).

Verification
REQ-037 clear 1 cycle, then correct D_FF, en=1, d_in toggling every 2 clk for 100 clk -> check_cnt=98, err_cnt=0, pass=1, mismatch never high.
REQ-038 Model forcing q_in stuck at 0, d_in=1 for 5 clk after PRIME -> mismatch=1 each compare cycle, err_q=1, err_comp=0, err_cnt=5.
REQ-039 qbar_in forced equal to q_in for 1 compare cycle -> one mismatch pulse, err_comp=1, err_cnt=1; STOP_ON_ERR=1 instance -> halted=1, check_cnt frozen at value including that compare.
REQ-040 en low 10 clk mid-run with d_in changing -> counters and d_prev hold; first compare after en returns uses pre-gap d_prev.
REQ-041 ERR_W=2, continuous failure for 6 compares -> err_cnt saturates at 3; clear asserted during a failing cycle -> all outputs 0, state IDLE, no mismatch pulse next cycle.

Source files
------------

// File: rtl/ff_check_pkg.sv
// Shared definitions for the flip-flop response checker: default counter
// widths, the checker state encoding and an X-pessimistic bit compare.
package ff_check_pkg;

    localparam int CNT_W_DEF = 16;
    localparam int ERR_W_DEF = 8;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE  = 2'd0;
    localparam state_t ST_PRIME = 2'd1;
    localparam state_t ST_CHECK = 2'd2;
    localparam state_t ST_HALT  = 2'd3;

    // Returns 1 unless a and b are known and equal. An unknown equality
    // result falls through the if, so X/Z on either side reads as a difference.
    function automatic logic bit_differs(input logic a, input logic b);
        logic diff;
        diff = 1'b1;
        if (a == b) diff = 1'b0;
        return diff;
    endfunction

endpackage

// File: rtl/ff_response_checker_sat_counter.sv
// Saturating up-counter with synchronous clear; stops at all-ones.
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         clear,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // next count: advance on inc unless already saturated
    always_comb begin
        cnt_d = cnt_q;
        if (inc && (cnt_q != {W{1'b1}})) begin
            cnt_d = cnt_q + {{(W-1){1'b0}}, 1'b1};
        end
    end

    // count register, clear wins
    always_ff @(posedge clk) begin
        if (clear) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/ff_response_checker.sv
// Checks a D flip-flop's Q/Qbar response against the D stream driven to it.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | after clear; first enabled cycle samples d_in, no compare
// PRIME | DUT output still undefined; sample d_in again, no compare
// CHECK | each enabled cycle compares Q to d_prev and Qbar to ~Q
// HALT  | frozen after first failure (STOP_ON_ERR only); left by clear
module ff_response_checker
    import ff_check_pkg::*;
#(
    parameter int CNT_W       = CNT_W_DEF,
    parameter int ERR_W       = ERR_W_DEF,
    parameter int STOP_ON_ERR = 0
) (
    input  logic             clk,
    input  logic             clear,
    input  logic             en,
    input  logic             d_in,
    input  logic             q_in,
    input  logic             qbar_in,
    output logic             mismatch,
    output logic             err_q,
    output logic             err_comp,
    output logic [CNT_W-1:0] check_cnt,
    output logic [ERR_W-1:0] err_cnt,
    output logic             pass,
    output logic             halted
);

    state_t state_q, state_d;
    logic   d_prev_q, d_prev_d;
    logic   mismatch_q, mismatch_d;
    logic   err_q_q, err_q_d;
    logic   err_comp_q, err_comp_d;

    logic   do_cmp;
    logic   fail_q_term;
    logic   fail_c_term;
    logic   cmp_fail;

    // sequencing, sampling of d_in and compare evaluation
    always_comb begin
        state_d     = state_q;
        d_prev_d    = d_prev_q;
        mismatch_d  = 1'b0;
        err_q_d     = err_q_q;
        err_comp_d  = err_comp_q;
        do_cmp      = 1'b0;
        cmp_fail    = 1'b0;
        fail_q_term = bit_differs(q_in, d_prev_q);
        fail_c_term = bit_differs(qbar_in, ~q_in);

        if (en) begin
            case (state_q)
                ST_IDLE: begin
                    d_prev_d = d_in;
                    state_d  = ST_PRIME;
                end
                ST_PRIME: begin
                    d_prev_d = d_in;
                    state_d  = ST_CHECK;
                end
                ST_CHECK: begin
                    do_cmp   = 1'b1;
                    d_prev_d = d_in;
                    if (fail_q_term || fail_c_term) begin
                        cmp_fail   = 1'b1;
                        mismatch_d = 1'b1;
                        err_q_d    = fail_q_term;
                        err_comp_d = fail_c_term;
                        if (STOP_ON_ERR != 0) state_d = ST_HALT;
                    end
                end
                ST_HALT: begin
                    state_d = ST_HALT;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // state, sample and flag registers; clear discards any same-cycle compare
    always_ff @(posedge clk) begin
        if (clear) begin
            state_q    <= ST_IDLE;
            d_prev_q   <= 1'b0;
            mismatch_q <= 1'b0;
            err_q_q    <= 1'b0;
            err_comp_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            d_prev_q   <= d_prev_d;
            mismatch_q <= mismatch_d;
            err_q_q    <= err_q_d;
            err_comp_q <= err_comp_d;
        end
    end

    sat_counter #(.W(CNT_W)) u_check_cnt (
        .clk   (clk),
        .clear (clear),
        .inc   (do_cmp),
        .cnt   (check_cnt)
    );

    sat_counter #(.W(ERR_W)) u_err_cnt (
        .clk   (clk),
        .clear (clear),
        .inc   (cmp_fail),
        .cnt   (err_cnt)
    );

    assign mismatch = mismatch_q;
    assign err_q    = err_q_q;
    assign err_comp = err_comp_q;
    assign pass     = (state_q == ST_CHECK) && (err_cnt == '0);
    assign halted   = (state_q == ST_HALT);

endmodule

// File: tb/tb_ff_response_checker.sv
// Bench for ff_response_checker: three instances (default, stop-on-error,
// 2-bit error counter) share one stimulus stream and are each compared every
// cycle against an abstract model, plus directed end-of-scenario checks.
module tb_ff_response_checker;

    logic clk;
    logic clear;
    logic en;
    logic d_in;
    logic q_in;
    logic qbar_in;

    logic        mis0, eq0, ec0, pass0, halt0;
    logic [15:0] chk0;
    logic [7:0]  err0;
    logic        mis1, eq1, ec1, pass1, halt1;
    logic [15:0] chk1;
    logic [7:0]  err1;
    logic        mis2, eq2, ec2, pass2, halt2;
    logic [15:0] chk2;
    logic [1:0]  err2;

    ff_response_checker u_def (
        .clk(clk), .clear(clear), .en(en), .d_in(d_in), .q_in(q_in), .qbar_in(qbar_in),
        .mismatch(mis0), .err_q(eq0), .err_comp(ec0), .check_cnt(chk0), .err_cnt(err0),
        .pass(pass0), .halted(halt0)
    );

    ff_response_checker #(.STOP_ON_ERR(1)) u_stop (
        .clk(clk), .clear(clear), .en(en), .d_in(d_in), .q_in(q_in), .qbar_in(qbar_in),
        .mismatch(mis1), .err_q(eq1), .err_comp(ec1), .check_cnt(chk1), .err_cnt(err1),
        .pass(pass1), .halted(halt1)
    );

    ff_response_checker #(.ERR_W(2)) u_sat (
        .clk(clk), .clear(clear), .en(en), .d_in(d_in), .q_in(q_in), .qbar_in(qbar_in),
        .mismatch(mis2), .err_q(eq2), .err_comp(ec2), .check_cnt(chk2), .err_cnt(err2),
        .pass(pass2), .halted(halt2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    endtask

    // model: enabled cycles since clear (0..2), sampled d, counts, flags
    int m_ph[3];
    bit m_dp[3];
    int m_chk[3];
    int m_err[3];
    bit m_mis[3];
    bit m_eq[3];
    bit m_ec[3];
    bit m_halt[3];
    int m_errmax[3] = '{255, 255, 3};
    bit m_stop[3]   = '{1'b0, 1'b1, 1'b0};

    bit q_ff;

    function automatic logic [31:0] obs(input int i, input int f);
        logic [31:0] r;
        r = '0;
        case (i)
            0: case (f) 0: r = mis0; 1: r = eq0; 2: r = ec0; 3: r = chk0; 4: r = err0; 5: r = pass0; default: r = halt0; endcase
            1: case (f) 0: r = mis1; 1: r = eq1; 2: r = ec1; 3: r = chk1; 4: r = err1; 5: r = pass1; default: r = halt1; endcase
            default: case (f) 0: r = mis2; 1: r = eq2; 2: r = ec2; 3: r = chk2; 4: r = err2; 5: r = pass2; default: r = halt2; endcase
        endcase
        return r;
    endfunction

    task automatic model_step();
        bit fq, fc;
        for (int i = 0; i < 3; i++) begin
            if (clear) begin
                m_ph[i] = 0; m_dp[i] = 0; m_chk[i] = 0; m_err[i] = 0;
                m_mis[i] = 0; m_eq[i] = 0; m_ec[i] = 0; m_halt[i] = 0;
            end else if (!en || m_halt[i]) begin
                m_mis[i] = 0;
            end else if (m_ph[i] < 2) begin
                m_ph[i]++;
                m_dp[i]  = d_in;
                m_mis[i] = 0;
            end else begin
                fq = (q_in != m_dp[i]);
                fc = (qbar_in == q_in);
                if (m_chk[i] < 65535) m_chk[i]++;
                m_mis[i] = fq | fc;
                if (fq | fc) begin
                    m_eq[i] = fq;
                    m_ec[i] = fc;
                    if (m_err[i] < m_errmax[i]) m_err[i]++;
                    if (m_stop[i]) m_halt[i] = 1;
                end
                m_dp[i] = d_in;
            end
        end
    endtask

    task automatic check_all();
        string nm[7] = '{"mismatch", "err_q", "err_comp", "check_cnt", "err_cnt", "pass", "halted"};
        logic [31:0] e;
        for (int i = 0; i < 3; i++) begin
            for (int f = 0; f < 7; f++) begin
                case (f)
                    0: e = 32'(m_mis[i]);
                    1: e = 32'(m_eq[i]);
                    2: e = 32'(m_ec[i]);
                    3: e = 32'(m_chk[i]);
                    4: e = 32'(m_err[i]);
                    5: e = 32'((m_ph[i] == 2) && !m_halt[i] && (m_err[i] == 0));
                    default: e = 32'(m_halt[i]);
                endcase
                chk($sformatf("inst%0d_%s", i, nm[f]), obs(i, f), e);
            end
        end
    endtask

    // fm: 0 good FF, 1 Q stuck 0, 2 Qbar==Q, 3 Q and Qbar both inverted, 4 random
    task automatic cycle(input bit c, input bit e, input bit d, input int fm);
        @(negedge clk);
        clear = c;
        en    = e;
        d_in  = d;
        case (fm)
            1:       begin q_in = 1'b0;  qbar_in = 1'b1;  end
            2:       begin q_in = q_ff;  qbar_in = q_ff;  end
            3:       begin q_in = ~q_ff; qbar_in = q_ff;  end
            4:       begin q_in = 1'($urandom); qbar_in = 1'($urandom); end
            default: begin q_in = q_ff;  qbar_in = ~q_ff; end
        endcase
        model_step();
        @(posedge clk);
        q_ff = d;
        #1;
        check_all();
    endtask

    initial begin
        clear = 1'b1; en = 1'b0; d_in = 1'b0; q_in = 1'b0; qbar_in = 1'b1;
        q_ff = 1'b0;

        // reset state
        cycle(1, 0, 0, 0);
        cycle(1, 1, 1, 0);
        chk("rst_cnt", chk0, 0);
        chk("rst_pass", pass0, 0);

        // correct FF, d toggling every 2 clk for 100 clk
        for (int k = 0; k < 100; k++) cycle(0, 1, 1'((k / 2) % 2), 0);
        chk("good_cnt", chk0, 98);
        chk("good_err", err0, 0);
        chk("good_pass", pass0, 1);

        // Q stuck at 0, d=1
        cycle(1, 0, 1, 0);
        cycle(0, 1, 1, 1);
        cycle(0, 1, 1, 1);
        for (int k = 0; k < 5; k++) cycle(0, 1, 1, 1);
        chk("stuck_err", err0, 5);
        chk("stuck_errq", eq0, 1);
        chk("stuck_errc", ec0, 0);
        chk("stuck_mis", mis0, 1);
        chk("stuck_halt_cnt", chk1, 1);
        cycle(0, 1, 1, 1);
        chk("sat_err", err2, 3);
        chk("sat_chk", chk2, 6);
        cycle(1, 1, 1, 1);
        chk("clr_err", err0, 0);
        chk("clr_mis", mis0, 0);
        cycle(0, 0, 1, 1);
        chk("clr_mis_next", mis0, 0);

        // single Qbar==Q cycle
        cycle(1, 0, 0, 0);
        cycle(0, 1, 1, 0);
        cycle(0, 1, 0, 0);
        for (int k = 0; k < 3; k++) cycle(0, 1, 1'($urandom), 0);
        cycle(0, 1, 1'($urandom), 2);
        chk("comp_mis", mis0, 1);
        for (int k = 0; k < 3; k++) cycle(0, 1, 1'($urandom), 0);
        chk("comp_err", err0, 1);
        chk("comp_errc", ec0, 1);
        chk("comp_errq", eq0, 0);
        chk("comp_halted", halt1, 1);
        chk("comp_frozen", chk1, 4);

        // en gap with d changing; resume must compare against pre-gap d_prev
        cycle(1, 0, 0, 0);
        cycle(0, 1, 1, 0);
        cycle(0, 1, 1, 0);
        for (int k = 0; k < 4; k++) cycle(0, 1, 1'($urandom), 0);
        cycle(0, 1, 0, 0);
        for (int k = 0; k < 10; k++) cycle(0, 0, 1'(k % 2), 0);
        chk("gap_cnt", chk0, 5);
        cycle(0, 1, 0, 0);
        chk("gap_mis", mis0, 1);
        chk("gap_errq", eq0, 1);
        chk("gap_cnt2", chk0, 6);

        // randomized traffic
        for (int k = 0; k < 400; k++) begin
            int fm;
            fm = ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, 4)) : 0;
            cycle(($urandom_range(0, 39) == 0), ($urandom_range(0, 3) != 0), 1'($urandom), fm);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
